// File: rtl/pipe_stage_reg.sv
// Parametrised pipeline stage register: valid/ready handshake, one-entry skid buffer,
// a hazard hold, and a flush with per-bit keep mask. Optional counters: PIPE_STAGE_PERF_EN.
module pipe_stage_reg #(
  parameter int unsigned       DATA_W    = 64,
  parameter logic [DATA_W-1:0] BUBBLE    = '0,
  parameter logic [DATA_W-1:0] KEEP_MASK = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  input  logic              hold,
  input  logic              flush
`ifdef PIPE_STAGE_PERF_EN
  ,
  output logic [15:0]       stall_cnt,
  output logic [15:0]       flush_cnt
`endif
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t            state;
  logic [DATA_W-1:0] main_data;
  logic [DATA_W-1:0] skid_data;
  logic [DATA_W-1:0] keep_load;
  logic              accept;
  logic              fire;

  // Squashed entry: kept fields (e.g. PC+4) survive, everything else becomes a NOP.
  assign keep_load = (in_data & KEEP_MASK) | (BUBBLE & ~KEEP_MASK);

  assign in_ready  = reset & (state != FULL) & ~hold & ~flush;
  assign out_valid = (state != EMPTY);
  assign out_data  = main_data;

  assign accept = in_valid & in_ready;
  assign fire   = out_valid & out_ready & ~hold;

  // NOTE: all state updates use non-blocking assignments so every register sees
  // pre-edge values; main_data tracks keep_load while reset is held low.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= EMPTY;
      main_data <= keep_load;
      skid_data <= BUBBLE;
    end else if (flush) begin
      state     <= EMPTY;
      main_data <= keep_load;
      skid_data <= BUBBLE;
    end else if (!hold) begin
      case (state)
        EMPTY: begin
          if (accept) begin
            state     <= ONE;
            main_data <= in_data;
          end
        end
        ONE: begin
          if (fire && accept) begin
            main_data <= in_data;
          end else if (fire) begin
            state     <= EMPTY;
            main_data <= BUBBLE;
          end else if (accept) begin
            state     <= FULL;
            skid_data <= in_data;
          end
        end
        FULL: begin
          // Skid only drains into main, so ordering stays FIFO.
          if (fire) begin
            state     <= ONE;
            main_data <= skid_data;
            skid_data <= BUBBLE;
          end
        end
        default: state <= EMPTY;
      endcase
    end
  end

`ifdef PIPE_STAGE_PERF_EN
  logic stall_ev;

  assign stall_ev = hold | (out_valid & ~out_ready);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall_ev && stall_cnt != 16'hFFFF) stall_cnt <= stall_cnt + 16'd1;
      if (flush && flush_cnt != 16'hFFFF)    flush_cnt <= flush_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Self-checking bench for pipe_stage_reg: queue scoreboard plus directed checks of
// reset, streaming, back-pressure, hold, flush and (if enabled) the perf counters.
module tb_pipe_stage_reg;

  localparam int unsigned DATA_W = 64;
  localparam logic [63:0] KEEP   = 64'h0000_0000_FFFF_FFFF;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [DATA_W-1:0] in_data = 64'h1234_5678_0000_0040;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [DATA_W-1:0] out_data;
  logic              hold = 1'b0;
  logic              flush = 1'b0;
`ifdef PIPE_STAGE_PERF_EN
  logic [15:0]       stall_cnt;
  logic [15:0]       flush_cnt;
`endif

  int unsigned       n_vec = 0;
  int unsigned       n_err = 0;
  logic              mon_en = 1'b0;
  logic [DATA_W-1:0] sb_q[$];

  always #5 clk = ~clk;

  pipe_stage_reg #(
    .DATA_W   (DATA_W),
    .BUBBLE   ('0),
    .KEEP_MASK(KEEP)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .hold     (hold),
    .flush    (flush)
`ifdef PIPE_STAGE_PERF_EN
    ,
    .stall_cnt(stall_cnt),
    .flush_cnt(flush_cnt)
`endif
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  // Inputs are stable from posedge+1 to the next posedge, so the negedge sees
  // exactly what the coming edge will act on.
  always @(negedge clk) begin
    if (mon_en && reset) begin
      check("out_valid", 64'(out_valid), 64'(sb_q.size() != 0));
      check("in_ready", 64'(in_ready), 64'((sb_q.size() < 2) && !hold && !flush));
      if (!out_valid) check("bubble_hi", 64'(out_data[63:32]), 64'h0);
      if (flush) begin
        sb_q.delete();
      end else begin
        if (out_valid && out_ready && !hold) begin
          if (sb_q.size() == 0) check("spurious_out", out_data, 64'hx);
          else                  check("sb_data", out_data, sb_q.pop_front());
        end
        if (in_valid && in_ready) sb_q.push_back(in_data);
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset: kept low bits load from in_data, the rest take BUBBLE.
    cycle();
    cycle();
    check("rst_out_valid", 64'(out_valid), 64'h0);
    check("rst_out_data", out_data, 64'h0000_0000_0000_0040);
    check("rst_in_ready", 64'(in_ready), 64'h0);
    reset = 1'b1;
    #1;
    check("rel_in_ready", 64'(in_ready), 64'h1);
    mon_en = 1'b1;

    // Streaming at full throughput.
    out_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      in_valid = 1'b1;
      in_data  = 64'(i);
      cycle();
      check("stream_valid", 64'(out_valid), 64'h1);
      check("stream_data", out_data, 64'(i));
    end
    in_valid = 1'b0;
    cycle();
    check("drain_valid", 64'(out_valid), 64'h0);
    check("drain_bubble", out_data, 64'h0);

    // Back-pressure: two accepts fill the stage, third waits upstream.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 64'd1;
    cycle();
    in_data = 64'd2;
    cycle();
    in_data = 64'd3;
    cycle();
    cycle();
    check("bp_in_ready", 64'(in_ready), 64'h0);
    check("bp_head", out_data, 64'd1);
    out_ready = 1'b1;
    cycle();
    check("bp_second", out_data, 64'd2);
    cycle();
    in_valid = 1'b0;
    check("bp_third", out_data, 64'd3);
    cycle();
    cycle();
    check("bp_empty", 64'(out_valid), 64'h0);

    // Hold: contents frozen, downstream ready ignored, input refused.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 64'd5;
    cycle();
    in_data   = 64'd6;
    hold      = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cycle();
      check("hold_data", out_data, 64'd5);
      check("hold_in_ready", 64'(in_ready), 64'h0);
    end
    hold = 1'b0;
    cycle();
    in_valid = 1'b0;
    check("post_hold_data", out_data, 64'd6);
    cycle();
    cycle();

    // Flush while FULL.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 64'd7;
    cycle();
    in_data = 64'd8;
    cycle();
    check("pre_flush_head", out_data, 64'd7);
    in_data = 64'hAAAA_AAAA_0000_0100;
    flush   = 1'b1;
    cycle();
    flush    = 1'b0;
    in_valid = 1'b0;
    check("flush_valid", 64'(out_valid), 64'h0);
    check("flush_data", out_data, 64'h0000_0000_0000_0100);

    // Flush together with hold still empties the stage.
    in_valid = 1'b1;
    in_data  = 64'd9;
    cycle();
    in_valid = 1'b0;
    in_data  = 64'hFFFF_0000_0000_0011;
    hold     = 1'b1;
    flush    = 1'b1;
    cycle();
    hold  = 1'b0;
    flush = 1'b0;
    check("flush_hold_valid", 64'(out_valid), 64'h0);
    check("flush_hold_data", out_data, 64'h0000_0000_0000_0011);
    cycle();

`ifdef PIPE_STAGE_PERF_EN
    mon_en = 1'b0;
    reset  = 1'b0;
    cycle();
    sb_q.delete();
    reset  = 1'b1;
    mon_en = 1'b1;
    check("perf_rst_stall", 64'(stall_cnt), 64'h0);
    check("perf_rst_flush", 64'(flush_cnt), 64'h0);
    hold = 1'b1;
    for (int i = 0; i < 3; i++) cycle();
    hold  = 1'b0;
    flush = 1'b1;
    for (int i = 0; i < 2; i++) cycle();
    flush = 1'b0;
    check("perf_stall", 64'(stall_cnt), 64'd3);
    check("perf_flush", 64'(flush_cnt), 64'd2);
    hold = 1'b1;
    for (int i = 0; i < 70000; i++) cycle();
    hold = 1'b0;
    check("perf_stall_sat", 64'(stall_cnt), 64'hFFFF);
    check("perf_flush_keep", 64'(flush_cnt), 64'd2);
`endif

    check("sb_residue", 64'(sb_q.size()), 64'h0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
